// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - UART boot loader that writes a framed image into the rom and holds the core in reset until done
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  output logic        w_en_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic [3:0]  w_sel_o,
  output logic        hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int          CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [16:0]      MAX_N     = 17'(MAX_WORDS);
  localparam logic [7:0]       HDR_BYTE  = 8'hA5;

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state, rx_next;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_last;
  logic             byte_vld;
  logic             frm_err;

  // rx_s3 only feeds the falling-edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    byte_vld = 1'b0;
    frm_err  = 1'b0;
    rx_last  = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    case (rx_state)
      RX_IDLE:  if (!rx_s2 && rx_s3) rx_next = RX_START;
      RX_START: if (rx_last) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_last && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_last) begin
          rx_next  = RX_IDLE;
          byte_vld = rx_s2;
          frm_err  = !rx_s2;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_last) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_last) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- frame FSM ----------------
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_AFTER_DATA = S_CSUM;
  logic [7:0] sum;
  logic [7:0] sum_chk;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t      state, state_next;
  logic [15:0] len;
  logic [15:0] n_full;
  logic [15:0] idx;
  logic [1:0]  lane;
  logic [23:0] asm_lo;
  logic        wr_fire;
  logic        start_frame;

  always_comb begin
    state_next  = state;
    wr_fire     = 1'b0;
    n_full      = {shift_byte(rx_shift), len[7:0]};
`ifdef LOADER_CHECKSUM_EN
    sum_chk     = sum + rx_shift;
`endif
    case (state)
      S_IDLE, S_ERR: if (byte_vld && rx_shift == HDR_BYTE) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (frm_err)       state_next = S_ERR;
        else if (byte_vld) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (frm_err) state_next = S_ERR;
        else if (byte_vld) begin
          if (n_full == 16'd0)              state_next = S_AFTER_DATA;
          else if ({1'b0, n_full} > MAX_N)  state_next = S_ERR;
          else                              state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (frm_err) state_next = S_ERR;
        else if (byte_vld && lane == 2'd3) begin
          wr_fire = 1'b1;
          if (idx == len - 16'd1) state_next = S_AFTER_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (frm_err)       state_next = S_ERR;
        else if (byte_vld) state_next = (sum_chk == 8'd0) ? S_DONE : S_ERR;
      end
`endif
      default: state_next = state;
    endcase
    start_frame = (state_next == S_LEN_LO) && (state != S_LEN_LO);
  end

  function automatic logic [7:0] shift_byte(input logic [7:0] b);
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len      <= '0;
      idx      <= '0;
      lane     <= '0;
      asm_lo   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
      w_en_o   <= 1'b0;
      w_addr_o <= '0;
      w_data_o <= '0;
      w_sel_o  <= '0;
    end else begin
      state  <= state_next;
      w_en_o <= wr_fire;
      if (start_frame) begin
        idx  <= '0;
        lane <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum  <= '0;
`endif
      end
      if (state == S_LEN_LO && byte_vld) len[7:0]  <= rx_shift;
      if (state == S_LEN_HI && byte_vld) len[15:8] <= rx_shift;
      if (state == S_DATA && byte_vld) begin
        lane <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        sum  <= sum + rx_shift;
`endif
        case (lane)
          2'd0: asm_lo[7:0]   <= rx_shift;
          2'd1: asm_lo[15:8]  <= rx_shift;
          2'd2: asm_lo[23:16] <= rx_shift;
          default: idx <= idx + 16'd1;
        endcase
      end
      // address/data/sel only move with a write, holding their last value otherwise
      if (wr_fire) begin
        w_addr_o <= BASE_ADDR + {14'd0, idx, 2'b00};
        w_data_o <= {rx_shift, asm_lo};
        w_sel_o  <= 4'hF;
      end
    end
  end

  assign hold_o = (state != S_DONE);
  assign done_o = (state == S_DONE);
  assign err_o  = (state == S_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader (follows LOADER_CHECKSUM_EN if defined)
module tb_rom_loader;

  localparam int          CLK_HZ = 1000000;
  localparam int          BAUD_R = 125000;
  localparam int          CPB    = CLK_HZ / BAUD_R;
  localparam logic [31:0] BASE   = 32'h1000_0100;

  logic        clk;
  logic        rst_n;
  logic        uart_rx;
  logic        w_en_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_sel_o;
  logic        hold_o;
  logic        done_o;
  logic        err_o;

  rom_loader #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD_R),
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (16384)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx_i(uart_rx),
    .w_en_o   (w_en_o),
    .w_addr_o (w_addr_o),
    .w_data_o (w_data_o),
    .w_sel_o  (w_sel_o),
    .hold_o   (hold_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bytes_sent = 0;
  int vld_count = 0;
  logic [63:0] sb[$];
  logic [31:0] img[$];
  logic vld_q = 1'b0, ferr_q = 1'b0, done_q = 1'b0, err_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w_en_o) begin
      check("wen_latency", {31'd0, vld_q}, 32'd1);
      if (sb.size() == 0) check("unexpected_wen", {31'd0, w_en_o}, 32'd0);
      else begin
        check("w_addr", w_addr_o, sb[0][63:32]);
        check("w_data", w_data_o, sb[0][31:0]);
        check("w_sel", {28'd0, w_sel_o}, 32'hF);
        void'(sb.pop_front());
      end
    end
    if (done_o && !done_q) check("done_latency", {31'd0, vld_q}, 32'd1);
    if (err_o && !err_q)   check("err_latency", {31'd0, vld_q | ferr_q}, 32'd1);
    if (dut.byte_vld) vld_count <= vld_count + 1;
    vld_q  <= dut.byte_vld;
    ferr_q <= dut.frm_err;
    done_q <= done_o;
    err_q  <= err_o;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    if (stop) bytes_sent++;
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] csum_adj, input bit expect_wr);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'd0;
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int i = 0; i < img.size(); i++) begin
      for (int l = 0; l < 4; l++) begin
        b = img[i][8*l +: 8];
        if (l == 3 && expect_wr) sb.push_back({BASE + 32'(4 * i), img[i]});
        send_byte(b, 1'b1);
        sum = sum + b;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(8'd0 - sum) + csum_adj, 1'b1);
`endif
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic check_status(input string tag, input logic h, input logic d, input logic e);
    @(negedge clk);
    check({tag, "_hold"}, {31'd0, hold_o}, {31'd0, h});
    check({tag, "_done"}, {31'd0, done_o}, {31'd0, d});
    check({tag, "_err"},  {31'd0, err_o},  {31'd0, e});
  endtask

  initial begin
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    #23 rst_n = 1'b1;

    // idle line after reset
    repeat (1000) @(posedge clk);
    check_status("reset", 1'b1, 1'b0, 1'b0);
    check("reset_waddr", w_addr_o, 32'd0);
    check("reset_wdata", w_data_o, 32'd0);
    check("reset_wsel", {28'd0, w_sel_o}, 32'd0);

    // quarter-bit low glitch in idle
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    check("glitch_no_byte", 32'(vld_count), 32'd0);
    check_status("glitch", 1'b1, 1'b0, 1'b0);

    // reference two-word image
    img = '{32'h12345678, 32'hDEADBEEF};
    send_frame(16'd2, 8'd0, 1'b1);
    check_status("load", 1'b0, 1'b1, 1'b0);
    check("load_sb_empty", 32'(sb.size()), 32'd0);

    // DONE ignores a further frame
    img = '{32'hCAFEF00D};
    send_frame(16'd1, 8'd0, 1'b0);
    check_status("done_sticky", 1'b0, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum: writes still land, then error; retry recovers
    do_reset();
    img = '{32'h12345678, 32'hDEADBEEF};
    send_frame(16'd2, 8'd1, 1'b1);
    check_status("bad_csum", 1'b1, 1'b0, 1'b1);
    send_frame(16'd2, 8'd0, 1'b1);
    check_status("csum_retry", 1'b0, 1'b1, 1'b0);
`endif

    // framing error in DATA, then retry
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    check_status("frm_err", 1'b1, 1'b0, 1'b1);
    img = '{32'h0BAD_F00D, 32'h7654_3210};
    send_frame(16'd2, 8'd0, 1'b1);
    check_status("frm_retry", 1'b0, 1'b1, 1'b0);

    // oversize length
    do_reset();
    img.delete();
    send_frame(16'h4001, 8'd0, 1'b0);
    check_status("oversize", 1'b1, 1'b0, 1'b1);

    // zero length
    do_reset();
    send_frame(16'd0, 8'd0, 1'b0);
    check_status("zero_len", 1'b0, 1'b1, 1'b0);

    // reset mid-frame after one word and two bytes of the next
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    sb.push_back({BASE, 32'hA1B2C3D4});
    send_byte(8'hD4, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_wen", {31'd0, w_en_o}, 32'd0);
    check("midrst_waddr", w_addr_o, 32'd0);
    check("midrst_wdata", w_data_o, 32'd0);
    check("midrst_wsel", {28'd0, w_sel_o}, 32'd0);
    check("midrst_hold", {31'd0, hold_o}, 32'd1);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_err", {31'd0, err_o}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    img = '{32'h0102_0304, 32'h8899_AABB, 32'hFFFF_0000};
    send_frame(16'd3, 8'd0, 1'b1);
    check_status("post_rst", 1'b0, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("byte_count", 32'(vld_count), 32'(bytes_sent));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
